// File: rtl/matriz_scan.sv
//------------------------------------------------------------------------------
// Module  : matriz_scan
// Brief   : Row-multiplexed 6x6 LED matrix driver with a double-buffered frame.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matriz_scan #(
   parameter int DWELL = 1000,
   parameter int BLANK = 4,
   parameter int CNT_W = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [35:0] frame_in,
   input  logic        frame_load,
   output logic [5:0]  row_sel,
   output logic [5:0]  col,
   output logic [2:0]  row_idx,
   output logic        pending,
   output logic        frame_ack
);

   localparam logic [0:0]       S_BLANK      = 1'b0;
   localparam logic [0:0]       S_DRIVE      = 1'b1;
   localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK - 1);
   localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
   localparam logic [2:0]       c_last_row   = 3'd5;

   logic [0:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_row_idx, w_row_nxt;
   logic [35:0]      r_display, w_display_nxt;
   logic [35:0]      r_pend_buf, w_pend_buf_nxt;
   logic             r_pending, w_pending_nxt;
   logic             r_frame_ack, w_ack_nxt;
   logic [5:0]       r_row_sel, w_row_sel_nxt;
   logic [5:0]       r_col, w_col_nxt;
   logic             w_wrap;

   // State and all outputs are registered together, so outputs track the state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= S_BLANK;
         r_cnt       <= '0;
         r_row_idx   <= '0;
         r_display   <= '0;
         r_pend_buf  <= '0;
         r_pending   <= 1'b0;
         r_frame_ack <= 1'b0;
         r_row_sel   <= '0;
         r_col       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_row_idx   <= w_row_nxt;
         r_display   <= w_display_nxt;
         r_pend_buf  <= w_pend_buf_nxt;
         r_pending   <= w_pending_nxt;
         r_frame_ack <= w_ack_nxt;
         r_row_sel   <= w_row_sel_nxt;
         r_col       <= w_col_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + c_cnt_one;
      w_row_nxt   = r_row_idx;
      w_wrap      = 1'b0;
      case (r_state)
         S_BLANK: begin
            if (r_cnt == c_blank_last) begin
               w_state_nxt = S_DRIVE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            if (r_cnt == c_dwell_last) begin
               w_state_nxt = S_BLANK;
               w_cnt_nxt   = '0;
               if (r_row_idx == c_last_row) begin
                  w_row_nxt = '0;
                  w_wrap    = 1'b1;
               end else begin
                  w_row_nxt = r_row_idx + 3'd1;
               end
            end
         end
      endcase
   end

   // The swap reads the old pending buffer, so a load on the wrap edge queues behind it.
   always_comb begin
      w_ack_nxt      = w_wrap & r_pending;
      w_display_nxt  = w_ack_nxt ? r_pend_buf : r_display;
      w_pend_buf_nxt = frame_load ? frame_in : r_pend_buf;
      w_pending_nxt  = frame_load | (r_pending & ~w_wrap);
      w_row_sel_nxt  = '0;
      w_col_nxt      = '0;
      if (w_state_nxt == S_DRIVE) begin
         case (w_row_nxt)
            3'd0:    begin w_row_sel_nxt = 6'b000001; w_col_nxt = r_display[5:0];   end
            3'd1:    begin w_row_sel_nxt = 6'b000010; w_col_nxt = r_display[11:6];  end
            3'd2:    begin w_row_sel_nxt = 6'b000100; w_col_nxt = r_display[17:12]; end
            3'd3:    begin w_row_sel_nxt = 6'b001000; w_col_nxt = r_display[23:18]; end
            3'd4:    begin w_row_sel_nxt = 6'b010000; w_col_nxt = r_display[29:24]; end
            default: begin w_row_sel_nxt = 6'b100000; w_col_nxt = r_display[35:30]; end
         endcase
      end
   end

   assign row_sel   = r_row_sel;
   assign col       = r_col;
   assign row_idx   = r_row_idx;
   assign pending   = r_pending;
   assign frame_ack = r_frame_ack;

endmodule

`default_nettype wire

// File: tb/tb_matriz_scan.sv
//------------------------------------------------------------------------------
// Module  : tb_matriz_scan
// Brief   : Bench for matriz_scan, DWELL=4/BLANK=2 and DWELL=1/BLANK=1 builds.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_matriz_scan;

   logic        clock = 1'b0;
   logic        reset;
   logic [35:0] frame_in;
   logic        frame_load;
   logic [5:0]  a_row_sel, a_col, b_row_sel, b_col;
   logic [2:0]  a_row_idx, b_row_idx;
   logic        a_pending, a_frame_ack, b_pending, b_frame_ack;

   always #5 clock = ~clock;

   matriz_scan #(.DWELL(4), .BLANK(2), .CNT_W(4)) dut_a (
      .clock(clock), .reset(reset), .frame_in(frame_in), .frame_load(frame_load),
      .row_sel(a_row_sel), .col(a_col), .row_idx(a_row_idx),
      .pending(a_pending), .frame_ack(a_frame_ack));

   matriz_scan #(.DWELL(1), .BLANK(1), .CNT_W(2)) dut_b (
      .clock(clock), .reset(reset), .frame_in(frame_in), .frame_load(frame_load),
      .row_sel(b_row_sel), .col(b_col), .row_idx(b_row_idx),
      .pending(b_pending), .frame_ack(b_frame_ack));

   // Frame-level reference: position follows from the cycle count since reset.
   typedef struct {
      int          k;
      logic [35:0] disp;
      logic [35:0] pbuf;
      logic        pend;
      logic        ack;
   } model_t;

   typedef struct {
      int          skip;
      logic        rn;
      logic        ld;
      logic [35:0] fin;
      logic [5:0]  rs;
      logic [5:0]  cl;
      logic [2:0]  idx;
      logic        pend;
      logic        ack;
   } vec_t;

   model_t ma, mb;
   int     n_tests = 0;
   int     n_fail  = 0;

   function automatic model_t adv(input model_t m, input int blank, input int dwell,
                                  input logic rn, input logic ld, input logic [35:0] fin);
      bit wrap;
      if (!rn) begin
         m.k = 0; m.disp = '0; m.pbuf = '0; m.pend = 1'b0; m.ack = 1'b0;
         return m;
      end
      m.k++;
      wrap  = (m.k % (6 * (blank + dwell))) == 0;
      m.ack = wrap && m.pend;
      if (m.ack) m.disp = m.pbuf;
      if (wrap) m.pend = 1'b0;
      if (ld) begin
         m.pbuf = fin;
         m.pend = 1'b1;
      end
      return m;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic chk_model(input string tag, input model_t m, input int blank, input int dwell,
                            input logic [5:0] rs, input logic [5:0] cl, input logic [2:0] idx,
                            input logic pend, input logic ack);
      int         phase, row;
      logic [5:0] ers, ecl;
      phase = m.k % (blank + dwell);
      row   = (m.k / (blank + dwell)) % 6;
      ers   = '0;
      ecl   = '0;
      if (phase >= blank) begin
         ers[row] = 1'b1;
         ecl      = m.disp[row*6 +: 6];
      end
      chk({tag, ".row_sel"},   {2'b0, rs},  {2'b0, ers});
      chk({tag, ".col"},       {2'b0, cl},  {2'b0, ecl});
      chk({tag, ".row_idx"},   {5'b0, idx}, 8'(row));
      chk({tag, ".pending"},   {7'b0, pend}, {7'b0, m.pend});
      chk({tag, ".frame_ack"}, {7'b0, ack},  {7'b0, m.ack});
   endtask

   function automatic logic [35:0] rnd36();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[35:0];
   endfunction

   task automatic step(input logic rn, input logic ld, input logic [35:0] fin);
      reset      = rn;
      frame_load = ld;
      frame_in   = fin;
      @(posedge clock);
      ma = adv(ma, 2, 4, rn, ld, fin);
      mb = adv(mb, 1, 1, rn, ld, fin);
      #1;
      chk_model("a", ma, 2, 4, a_row_sel, a_col, a_row_idx, a_pending, a_frame_ack);
      chk_model("b", mb, 1, 1, b_row_sel, b_col, b_row_idx, b_pending, b_frame_ack);
   endtask

   localparam logic [35:0] c_border = 36'hFE186187F;
   localparam logic [35:0] c_fa     = 36'h123456789;
   localparam logic [35:0] c_fb     = 36'h0F0F0F0F0;

   vec_t tbl[26];

   initial begin
      tbl[0]  = '{0,  1'b0, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b0};
      tbl[1]  = '{0,  1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b0};
      tbl[2]  = '{0,  1'b1, 1'b0, 36'h0,    6'h01, 6'h00, 3'd0, 1'b0, 1'b0};
      tbl[3]  = '{3,  1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd1, 1'b0, 1'b0};
      tbl[4]  = '{1,  1'b1, 1'b0, 36'h0,    6'h02, 6'h00, 3'd1, 1'b0, 1'b0};
      tbl[5]  = '{5,  1'b1, 1'b1, c_border, 6'h04, 6'h00, 3'd2, 1'b1, 1'b0};
      tbl[6]  = '{20, 1'b1, 1'b0, 36'h0,    6'h20, 6'h00, 3'd5, 1'b1, 1'b0};
      tbl[7]  = '{0,  1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b1};
      tbl[8]  = '{0,  1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b0};
      tbl[9]  = '{0,  1'b1, 1'b0, 36'h0,    6'h01, 6'h3F, 3'd0, 1'b0, 1'b0};
      tbl[10] = '{5,  1'b1, 1'b0, 36'h0,    6'h02, 6'h21, 3'd1, 1'b0, 1'b0};
      tbl[11] = '{29, 1'b1, 1'b0, 36'h0,    6'h01, 6'h3F, 3'd0, 1'b0, 1'b0};
      tbl[12] = '{0,  1'b1, 1'b1, c_fa,     6'h01, 6'h3F, 3'd0, 1'b1, 1'b0};
      tbl[13] = '{10, 1'b1, 1'b1, c_fb,     6'h04, 6'h21, 3'd2, 1'b1, 1'b0};
      tbl[14] = '{21, 1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b1};
      tbl[15] = '{1,  1'b1, 1'b0, 36'h0,    6'h01, 6'h30, 3'd0, 1'b0, 1'b0};
      tbl[16] = '{0,  1'b1, 1'b1, c_fa,     6'h01, 6'h30, 3'd0, 1'b1, 1'b0};
      tbl[17] = '{32, 1'b1, 1'b1, c_fb,     6'h00, 6'h00, 3'd0, 1'b1, 1'b1};
      tbl[18] = '{1,  1'b1, 1'b0, 36'h0,    6'h01, 6'h09, 3'd0, 1'b1, 1'b0};
      tbl[19] = '{33, 1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b1};
      tbl[20] = '{1,  1'b1, 1'b1, c_fa,     6'h01, 6'h30, 3'd0, 1'b1, 1'b0};
      tbl[21] = '{18, 1'b0, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b0};
      tbl[22] = '{0,  1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b0};
      tbl[23] = '{0,  1'b1, 1'b0, 36'h0,    6'h01, 6'h00, 3'd0, 1'b0, 1'b0};
      tbl[24] = '{32, 1'b1, 1'b0, 36'h0,    6'h20, 6'h00, 3'd5, 1'b0, 1'b0};
      tbl[25] = '{0,  1'b1, 1'b0, 36'h0,    6'h00, 6'h00, 3'd0, 1'b0, 1'b0};

      reset      = 1'b0;
      frame_load = 1'b0;
      frame_in   = '0;

      // Directed sequence: idle cycles carry random frame_in with no strobe.
      for (int i = 0; i < 26; i++) begin
         repeat (tbl[i].skip) step(1'b1, 1'b0, rnd36());
         step(tbl[i].rn, tbl[i].ld, tbl[i].fin);
         chk($sformatf("tbl[%0d].row_sel", i),   {2'b0, a_row_sel},  {2'b0, tbl[i].rs});
         chk($sformatf("tbl[%0d].col", i),       {2'b0, a_col},      {2'b0, tbl[i].cl});
         chk($sformatf("tbl[%0d].row_idx", i),   {5'b0, a_row_idx},  {5'b0, tbl[i].idx});
         chk($sformatf("tbl[%0d].pending", i),   {7'b0, a_pending},  {7'b0, tbl[i].pend});
         chk($sformatf("tbl[%0d].frame_ack", i), {7'b0, a_frame_ack}, {7'b0, tbl[i].ack});
      end

      // Randomized loads with occasional reset pulses, checked against the model.
      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(0, 499) != 0, $urandom_range(0, 24) == 0, rnd36());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/matriz_scan.md
Name: matriz_scan

Overview:
- Consumes the 36-bit LED frame (6x6 matrix, bit index = row*6 + col, row 0 = bits 5:0) produced by the game's frame generator.
- Drives the physical matrix by time-multiplexing: one row active at a time, with column data for that row.
- Double-buffered: a newly loaded frame is shown only at a frame boundary, so the display never tears.
- Sits between the snake/apple frame logic and the board's row/column pins.

Parameters:
- DWELL, 1000, clock cycles each row is driven (>=1)
- BLANK, 4, all-off clock cycles before each row is driven (>=1)
- CNT_W, 16, width of the internal cycle counter; must hold max(DWELL, BLANK)-1

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- frame_in  in  36  frame to display, bit r*6+c = row r, column c
- frame_load  in  1  single-cycle strobe: capture frame_in into pending buffer
- row_sel  out  6  one-hot active row, active-high; all zero while blanking
- col  out  6  column data for the active row, col[c] = display[r*6+c]; zero while blanking
- row_idx  out  3  current row index 0..5
- pending  out  1  pending buffer holds a frame not yet displayed
- frame_ack  out  1  one-cycle pulse when pending frame is transferred to the display buffer

Behaviour:
- All outputs registered. Reset (reset==0 at clock edge) takes effect that edge, including mid-row or mid-blank:
  - row_sel=0, col=0, row_idx=0, pending=0, frame_ack=0
  - display buffer=0, pending buffer=0, state=S_BLANK, cnt=0
- Two-state FSM, cnt counts cycles in the current state:
  - S_BLANK: row_sel=0, col=0.
    - cnt==BLANK-1 -> S_DRIVE, cnt=0.
    - Otherwise cnt++.
  - S_DRIVE: row_sel[row_idx]=1, col=display[row_idx*6 +: 6].
    - cnt==DWELL-1 -> S_BLANK, cnt=0, row_idx = (row_idx==5) ? 0 : row_idx+1.
    - Otherwise cnt++.
- Outputs reflect the registered state:
  - First S_DRIVE cycle after reset is clock edge BLANK+1.
  - Row period = BLANK+DWELL cycles; frame period = 6*(BLANK+DWELL).
- Load:
  - frame_load=1 at an edge -> pending buffer <= frame_in, pending <= 1.
  - Load while pending==1 overwrites the buffer (latest frame wins, no error).
- Swap: occurs on the edge that leaves S_DRIVE of row 5 (wrap to row 0).
  - If pending==1: display <= pending buffer, frame_ack=1 for exactly that next cycle, pending <= 0.
  - If pending==0: display unchanged, frame_ack=0.
- Simultaneous load and swap on the same edge:
  - Display takes the OLD pending buffer.
  - Pending buffer takes frame_in; pending stays 1; frame_ack=1.
- Display buffer never changes except at swap or reset; col never changes within a row's dwell.
- frame_in is sampled only when frame_load=1; otherwise ignored.
- row_sel is never more than one-hot; it is zero for the full BLANK interval of every row.

Test Plan (DWELL=4, BLANK=2, frame period 36):
- Reset, no load -> cycles 1-2: row_sel=0. Cycles 3-6: row_sel=6'b000001, col=0. Cycles 9-12: row_sel=6'b000010. Row 5 then wraps back to row 0. frame_ack never asserts.
- Border frame load (frame_in bits 6:0, 12:11, 18:17, 24:23, 35:29 set) during row 2 -> pending=1 and display unchanged until row 5 ends. Then frame_ack=1 for one cycle, pending=0. Next frame: row0 col=111111, row1 col=100001, row2-4 col=100001, row5 col=111111.
- Two loads in one frame (A, then B) -> frame B shown after wrap; A never appears; a single frame_ack.
- Load B on exactly the swap edge while A is pending -> A displayed, frame_ack=1, pending stays 1. B displayed after the next wrap with a second frame_ack.
- reset=0 for one cycle during row 3 drive -> next cycle row_sel=0, col=0, row_idx=0, pending=0. Scan restarts with row 0 drive 2 cycles after release, col=0.
- DWELL=1, BLANK=1 build -> row_sel alternates 0 and one-hot each cycle; frame period 12; swap and ack rules unchanged.
